dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
// Control and sequencing front-end for the DDS core. Generates the sample-rate strobe that clocks the phase
// accumulator/LFSR and owns the tuning word and waveform select driving accumulator and output mux.
// Host loads shadow registers over a byte-wide write port; values commit glitch-free on a strobe, optionally
// at phase wrap. Also runs a linear frequency sweep (chirp) from the committed word to an end word.
// PARAMETERS
// TUNE   16  tuning word width (9..16); byte-map bits above TUNE-1 ignored
// DIV    14  master clocks per sample strobe (>=2)
// DWELL  8   width of dwell counter (sample strobes per sweep step)
// PORTS
// clk          in   1     master clock (50 MHz)
// rst          in   1     synchronous reset, active-high
// wr_en        in   1     write strobe, one byte per cycle
// wr_addr      in   3     register address
// wr_data      in   8     write data
// phase_wrap   in   1     accumulator rollover flag, valid in strobe cycle
// sample_tick  out  1     one-cycle strobe every DIV clocks; accumulator enable
// tuning_word  out  TUNE  live tuning word to accumulator
// wave_sel     out  3     live mux select (0 sine,1 saw,2 pulse,3 tri,4 noise)
// acc_clr      out  1     one-cycle accumulator clear, coincident with a sample_tick
// sweep_active out  1     high while in SWEEP
// sweep_done   out  1     one-cycle pulse when sweep reaches end word
// BEHAVIOUR
// Reset: all outputs 0, tick counter 0, all shadow regs 0, FSM=IDLE, dwell counter 0.
// Tick: counter counts 0..DIV-1, wraps; sample_tick=1 exactly when counter==DIV-1 (first tick at cycle DIV after reset release).
// Reg map (write-only, registered on wr_en):
//   0 TW lo, 1 TW hi, 2 SEL[2:0], 4 STEP lo, 5 STEP hi, 6 END lo, 7 END hi (shadow regs)
//   3 CTRL: b0 COMMIT, b1 SWEEP_GO, b2 SWEEP_STOP, b3 SYNC_WRAP (sticky mode bit), b4 ACC_CLR; b0/b1/b2/b4 self-clearing
// Live outputs (tuning_word, wave_sel, acc_clr) change only on clocks edges ending a sample_tick cycle.
// FSM states IDLE, PEND, SWEEP:
//   IDLE: COMMIT -> PEND. SWEEP_GO -> SWEEP: tuning_word<=shadow TW, dwell cleared.
//   PEND: on sample_tick, if SYNC_WRAP=0 or phase_wrap=1: tuning_word<=TW, wave_sel<=SEL -> IDLE; else hold.
//   SWEEP: each sample_tick, dwell++; when dwell reaches 2^DWELL-1, dwell<=0 and
//     tuning_word<=min(tuning_word+STEP, END) computed TUNE+1 bits wide (no wrap).
//     When loaded value==END: sweep_done pulses same edge, -> IDLE.
//     SWEEP_STOP: -> IDLE next edge, tuning_word frozen, no sweep_done.
//     COMMIT in SWEEP: abort sweep -> PEND (no sweep_done).
// Priority in same CTRL write: STOP > COMMIT > GO. SWEEP_GO with END<=TW: loads TW, sweep_done pulses on first step, -> IDLE.
// STEP=0 in SWEEP: tuning word holds until STOP/COMMIT.
// ACC_CLR: latch request; acc_clr=1 for one cycle aligned with next sample_tick, independent of FSM.
// Shadow writes never disturb live outputs until commit/sweep load. Writes in same cycle as a commit take
// effect at that commit only if written a cycle earlier.
// Reset mid-PEND/SWEEP: return to IDLE, outputs 0, SYNC_WRAP cleared.
// sweep_active = (state==SWEEP), registered.
// TESTING
// T1 reset then idle 40 clks (DIV=14): sample_tick high at cycles 14,28 only; all other outputs 0.
// T2 TW=0x1234, SEL=3, COMMIT (SYNC_WRAP=0): outputs 0x1234/3 appear after next tick, not before.
// T3 SYNC_WRAP=1, COMMIT, phase_wrap low 3 ticks then high: update exactly on the 4th tick.
// T4 DWELL=2, TW=0x0100, STEP=0x0100, END=0x0350, GO: word steps 0x0200,0x0300, then 0x0350 + sweep_done.
// T5 during SWEEP, CTRL=0x07 (STOP+COMMIT+GO): IDLE, word frozen, no sweep_done, no PEND.
// T6 ACC_CLR with rst asserted mid-PEND: acc_clr never fires; all outputs 0 after reset edge.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sample strobe, shadow regs, commit FSM, linear chirp.
// In: clk_i rst_i wr_en_i wr_addr_i wr_data_i phase_wrap_i; Out: sample_tick_o tuning_word_o wave_sel_o acc_clr_o sweep_active_o sweep_done_o
module dds_sweep_ctrl #(
  parameter int TUNE  = 16,
  parameter int DIV   = 14,
  parameter int DWELL = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_addr_i,
  input  logic [7:0]      wr_data_i,
  input  logic            phase_wrap_i,
  output logic            sample_tick_o,
  output logic [TUNE-1:0] tuning_word_o,
  output logic [2:0]      wave_sel_o,
  output logic            acc_clr_o,
  output logic            sweep_active_o,
  output logic            sweep_done_o
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_SWEEP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick;

  logic [15:0]     tw_sh_q, step_sh_q, end_sh_q;
  logic [2:0]      sel_sh_q;
  logic            sync_q, commit_q, go_q, stop_q;
  logic            clr_req_q;
  logic            ctrl_wr;

  logic [TUNE-1:0] tw_q, tw_d;
  logic [2:0]      sel_q, sel_d;
  logic [DWELL-1:0] dwell_q, dwell_d;
  logic            load_q, load_d;
  logic            done_q, done_d;

  logic [TUNE:0]   sum;
  logic [TUNE:0]   end_ext;
  logic            hit_end;
  logic [TUNE-1:0] nxt;

  assign tick    = (cnt_q == CNT_MAX);
  assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
  assign ctrl_wr = wr_en_i && (wr_addr_i == 3'd3);

  // Step computed one bit wider so the clamp to END never sees a wrap.
  assign sum     = {1'b0, tw_q} + {1'b0, step_sh_q[TUNE-1:0]};
  assign end_ext = {1'b0, end_sh_q[TUNE-1:0]};
  assign hit_end = (sum >= end_ext);
  assign nxt     = hit_end ? end_sh_q[TUNE-1:0] : sum[TUNE-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      tw_sh_q   <= '0;
      step_sh_q <= '0;
      end_sh_q  <= '0;
      sel_sh_q  <= '0;
      sync_q    <= 1'b0;
      commit_q  <= 1'b0;
      go_q      <= 1'b0;
      stop_q    <= 1'b0;
      clr_req_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      commit_q  <= ctrl_wr & wr_data_i[0];
      go_q      <= ctrl_wr & wr_data_i[1];
      stop_q    <= ctrl_wr & wr_data_i[2];
      if (ctrl_wr) begin
        sync_q <= wr_data_i[3];
      end
      // Request consumed by the tick it fires on; a new one arms the next.
      clr_req_q <= (clr_req_q & ~tick) | (ctrl_wr & wr_data_i[4]);
      if (wr_en_i) begin
        case (wr_addr_i)
          3'd0:    tw_sh_q[7:0]    <= wr_data_i;
          3'd1:    tw_sh_q[15:8]   <= wr_data_i;
          3'd2:    sel_sh_q        <= wr_data_i[2:0];
          3'd4:    step_sh_q[7:0]  <= wr_data_i;
          3'd5:    step_sh_q[15:8] <= wr_data_i;
          3'd6:    end_sh_q[7:0]   <= wr_data_i;
          3'd7:    end_sh_q[15:8]  <= wr_data_i;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tw_q    <= '0;
      sel_q   <= '0;
      dwell_q <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tw_q    <= tw_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tw_d    = tw_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    load_d  = load_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stop_q) begin
          if (commit_q) begin
            state_d = S_PEND;
          end else if (go_q) begin
            // Start word is loaded on the next tick edge.
            state_d = S_SWEEP;
            load_d  = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (tick && (!sync_q || phase_wrap_i)) begin
          tw_d    = tw_sh_q[TUNE-1:0];
          sel_d   = sel_sh_q;
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (stop_q) begin
          state_d = S_IDLE;
          load_d  = 1'b0;
        end else if (commit_q) begin
          state_d = S_PEND;
          load_d  = 1'b0;
        end else if (tick) begin
          if (load_q) begin
            tw_d    = tw_sh_q[TUNE-1:0];
            dwell_d = '0;
            load_d  = 1'b0;
          end else if (dwell_q == '1) begin
            dwell_d = '0;
            tw_d    = nxt;
            if (hit_end) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_tick_o  = tick;
  assign tuning_word_o  = tw_q;
  assign wave_sel_o     = sel_q;
  assign acc_clr_o      = clr_req_q & tick;
  assign sweep_active_o = (state_q == S_SWEEP);
  assign sweep_done_o   = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed bench for dds_sweep_ctrl with a
// per-cycle reference model and literal checkpoints.
module tb_dds_sweep_ctrl;
  localparam int TUNE  = 16;
  localparam int DIV   = 14;
  localparam int DWELL = 2;
  localparam int NDW   = 1 << DWELL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        phase_wrap = 1'b0;
  logic        sample_tick;
  logic [15:0] tuning_word;
  logic [2:0]  wave_sel;
  logic        acc_clr;
  logic        sweep_active;
  logic        sweep_done;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .TUNE (TUNE),
    .DIV  (DIV),
    .DWELL(DWELL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .phase_wrap_i  (phase_wrap),
    .sample_tick_o (sample_tick),
    .tuning_word_o (tuning_word),
    .wave_sel_o    (wave_sel),
    .acc_clr_o     (acc_clr),
    .sweep_active_o(sweep_active),
    .sweep_done_o  (sweep_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 pending commit, 2 sweeping.
  int          m_cnt, m_mode, m_base, m_n, m_w;
  bit          m_loaded, m_done, m_clr, m_t;
  bit          c_valid, e_go, e_stop, e_commit;
  logic [7:0]  c_prev;
  logic [15:0] m_tw, s_tw, s_step, s_end;
  logic [2:0]  m_sel, s_sel;
  bit          s_sync;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_tw = '0; m_sel = '0;
      m_done = 0; m_clr = 0; m_loaded = 0; m_n = 0;
      s_tw = '0; s_step = '0; s_end = '0; s_sel = '0;
      s_sync = 0; c_valid = 0; c_prev = '0;
    end else begin
      m_t = (m_cnt % DIV) == DIV - 1;
      m_done = 0;
      if (m_t) m_clr = 0;
      e_go = c_valid && c_prev[1];
      e_stop = c_valid && c_prev[2];
      e_commit = c_valid && c_prev[0];
      case (m_mode)
        0: if (!e_stop) begin
          if (e_commit) m_mode = 1;
          else if (e_go) begin m_mode = 2; m_loaded = 0; end
        end
        1: if (m_t && (!s_sync || phase_wrap)) begin
          m_tw = s_tw; m_sel = s_sel; m_mode = 0;
        end
        default: begin
          if (e_stop) m_mode = 0;
          else if (e_commit) m_mode = 1;
          else if (m_t) begin
            if (!m_loaded) begin
              m_tw = s_tw; m_base = int'(s_tw); m_n = 0; m_loaded = 1;
            end else begin
              m_n++;
              if (m_n % NDW == 0) begin
                m_w = m_base + (m_n / NDW) * int'(s_step);
                if (m_w >= int'(s_end)) m_w = int'(s_end);
                m_tw = 16'(m_w);
                if (m_w == int'(s_end)) begin m_done = 1; m_mode = 0; end
              end
            end
          end
        end
      endcase
      c_valid = 0;
      if (wr_en) begin
        case (wr_addr)
          3'd0: s_tw[7:0] = wr_data;
          3'd1: s_tw[15:8] = wr_data;
          3'd2: s_sel = wr_data[2:0];
          3'd3: begin
            c_prev = wr_data; c_valid = 1; s_sync = wr_data[3];
            if (wr_data[4]) m_clr = 1;
          end
          3'd4: s_step[7:0] = wr_data;
          3'd5: s_step[15:8] = wr_data;
          3'd6: s_end[7:0] = wr_data;
          default: s_end[15:8] = wr_data;
        endcase
      end
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      m_t = (m_cnt % DIV) == DIV - 1;
      chk("tick", 32'(sample_tick), 32'(m_t));
      chk("tw", 32'(tuning_word), 32'(m_tw));
      chk("sel", 32'(wave_sel), 32'(m_sel));
      chk("accclr", 32'(acc_clr), 32'(m_clr && m_t));
      chk("active", 32'(sweep_active), 32'(m_mode == 2));
      chk("done", 32'(sweep_done), 32'(m_done));
    end
    if (sweep_done) done_cnt++;
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns at the negedge inside the next tick cycle.
  task automatic to_tick();
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (sample_tick) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick_end();
    to_tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int n, first, second, nz, coinc, d0;
    bit seen;
    logic [15:0] last;
    logic [15:0] seq[$];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;

    // T1: tick at cycles 14 and 28, everything else quiet
    n = 0; first = 0; second = 0; nz = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sample_tick) begin
        n++;
        if (n == 1) first = c;
        else if (n == 2) second = c;
      end
      if (tuning_word != 0 || wave_sel != 0 || acc_clr ||
          sweep_active || sweep_done) nz++;
      @(posedge clk); #1;
    end
    chk("t1_nticks", 32'(n), 32'd2);
    chk("t1_first", 32'(first), 32'd14);
    chk("t1_second", 32'(second), 32'd28);
    chk("t1_quiet", 32'(nz), 32'd0);

    // T2: plain commit lands on the tick edge
    wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'h03);
    wr(3'd3, 8'h01); idle(1);
    to_tick();
    chk("t2_before", 32'(tuning_word), 32'h0);
    @(posedge clk); #1;
    chk("t2_tw", 32'(tuning_word), 32'h1234);
    chk("t2_sel", 32'(wave_sel), 32'd3);

    // T3: sync-to-wrap commit waits for phase_wrap
    wr(3'd3, 8'h08); wr(3'd0, 8'h78); wr(3'd1, 8'h56);
    wr(3'd2, 8'h01); wr(3'd3, 8'h09); idle(1);
    for (int k = 1; k <= 4; k++) begin
      to_tick();
      if (k == 4) phase_wrap = 1'b1;
      @(posedge clk); #1;
      phase_wrap = 1'b0;
      if (k < 4) chk("t3_hold", 32'(tuning_word), 32'h1234);
    end
    chk("t3_tw", 32'(tuning_word), 32'h5678);
    chk("t3_sel", 32'(wave_sel), 32'd1);
    wr(3'd3, 8'h00);

    // accumulator clear: exactly one pulse, on a tick
    wr(3'd3, 8'h10);
    n = 0; coinc = 0;
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge clk);
      if (acc_clr) begin n++; if (sample_tick) coinc++; end
      @(posedge clk); #1;
    end
    chk("clr_count", 32'(n), 32'd1);
    chk("clr_on_tick", 32'(coinc), 32'd1);

    // T4: chirp 0x0100 -> 0x0350 in 0x0100 steps
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd4, 8'h00);
    wr(3'd5, 8'h01); wr(3'd6, 8'h50); wr(3'd7, 8'h03);
    wr(3'd3, 8'h02); idle(1);
    chk("t4_active", 32'(sweep_active), 32'd1);
    last = tuning_word; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick_end();
      if (tuning_word != last) begin
        seq.push_back(tuning_word);
        last = tuning_word;
      end
      if (sweep_done) seen = 1;
    end
    chk("t4_nsteps", 32'(seq.size()), 32'd4);
    if (seq.size() == 4) begin
      chk("t4_w0", 32'(seq[0]), 32'h0100);
      chk("t4_w1", 32'(seq[1]), 32'h0200);
      chk("t4_w2", 32'(seq[2]), 32'h0300);
      chk("t4_w3", 32'(seq[3]), 32'h0350);
    end
    chk("t4_done", 32'(seen), 32'd1);
    idle(1);
    chk("t4_idle", 32'(sweep_active), 32'd0);

    // T5: STOP+COMMIT+GO in one write freezes the sweep
    wr(3'd3, 8'h02);
    for (int k = 0; k < 12 && tuning_word != 16'h0200; k++) tick_end();
    chk("t5_reach", 32'(tuning_word), 32'h0200);
    d0 = done_cnt;
    wr(3'd3, 8'h07); idle(1);
    chk("t5_active", 32'(sweep_active), 32'd0);
    for (int k = 0; k < 3; k++) tick_end();
    chk("t5_frozen", 32'(tuning_word), 32'h0200);
    chk("t5_nodone", 32'(done_cnt - d0), 32'd0);

    // END below start word: lands on END at the first step
    wr(3'd0, 8'h00); wr(3'd1, 8'h04); wr(3'd3, 8'h02);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick_end();
      if (sweep_done) seen = 1;
    end
    chk("end_low_done", 32'(seen), 32'd1);
    chk("end_low_tw", 32'(tuning_word), 32'h0350);

    // T6: reset in PEND with a clear request outstanding
    tick_end();
    wr(3'd0, 8'hAA); wr(3'd3, 8'h09); wr(3'd3, 8'h18);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("t6_tw", 32'(tuning_word), 32'h0);
    chk("t6_sel", 32'(wave_sel), 32'd0);
    chk("t6_active", 32'(sweep_active), 32'd0);
    n = 0;
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge clk);
      if (acc_clr) n++;
      @(posedge clk); #1;
    end
    chk("t6_noclr", 32'(n), 32'd0);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
